ntt_zeta_butterfly: RTL and testbench

- Pipelined Kyber butterfly unit that sits directly downstream of the 128-entry 12-bit zeta pROM (dist_mem_gen_7).
- Drives the ROM address, enables and output enable, and consumes its registered zeta output.
- Performs one Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT) butterfly modulo q=3329 per accepted beat, using valid/ready flow control.
- Consumed by the NTT/INTT sequencer and the coefficient RAM write-back path.

---
 rtl/ntt_zeta_butterfly.sv | 212 +++++++++++++++++++++
 tb/tb_ntt_zeta_butterfly.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_zeta_butterfly.sv
// ntt_zeta_butterfly: four-stage Kyber butterfly (q = 3329).
// It sits behind the registered 128 x 12-bit zeta ROM. It supports Cooley-Tukey
// (forward) and Gentleman-Sande (inverse) modes, chosen per beat.
// A global stall freezes every stage and the ROM output while the result
// register is held by downstream.
module ntt_zeta_butterfly #(
   parameter int DATA_W = 12,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [6:0]        in_zeta_idx,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [6:0]        rom_ad,
   output logic              rom_ce,
   output logic              rom_oce,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int PW  = 2 * DATA_W;   // full product width
   localparam int MW  = 13;           // width of the Barrett constant
   localparam int BW  = PW + MW;      // p * 5039
   localparam int QEW = BW - PW;      // quotient estimate width
   localparam int RW  = PW + 1;       // remainder working width

   localparam logic [DATA_W-1:0] Q         = DATA_W'(3329);
   localparam logic [DATA_W:0]   Q_EXT     = (DATA_W + 1)'(3329);
   localparam logic [RW-1:0]     Q_RW      = RW'(3329);
   localparam logic [MW-1:0]     BARRETT_M = MW'(5039);
   localparam int                BARRETT_SHIFT = 24;

   // (x + y) mod q for x, y already in [0, q)
   function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
      logic [DATA_W:0] t;
      t = {1'b0, x} + {1'b0, y};
      if (t >= Q_EXT) t = t - Q_EXT;
      return DATA_W'(t);
   endfunction

   // (x - y) mod q for x, y already in [0, q)
   function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
      logic [DATA_W:0] t;
      if (x >= y) t = {1'b0, x} - {1'b0, y};
      else        t = {1'b0, x} + Q_EXT - {1'b0, y};
      return DATA_W'(t);
   endfunction

   // ------------------------------------------------------------------
   // Flow control and ROM interface
   // ------------------------------------------------------------------
   logic stall;
   logic advance;

   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = advance;
   assign rom_ad   = in_zeta_idx;
   assign rom_ce   = advance;
   assign rom_oce  = 1'b1;

   // ------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------
   logic              s1_valid;
   logic              s1_mode;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [TAG_W-1:0]  s1_tag;

   logic              s2_valid;
   logic              s2_mode;
   logic [PW-1:0]     s2_p;
   logic [DATA_W-1:0] s2_op;
   logic [TAG_W-1:0]  s2_tag;

   logic              s3_valid;
   logic              s3_mode;
   logic [DATA_W-1:0] s3_r;
   logic [DATA_W-1:0] s3_op;
   logic [TAG_W-1:0]  s3_tag;

   // ------------------------------------------------------------------
   // S1 combinational: GS pre-add/sub and the zeta multiply
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] s1_sum;
   logic [DATA_W-1:0] s1_diff;
   logic [DATA_W-1:0] s1_mul_in;
   logic [DATA_W-1:0] s1_op;
   logic [PW-1:0]     s1_p;

   // CT multiplies b by zeta; GS multiplies (a - b) by zeta and forwards a + b
   always_comb begin
      s1_sum    = mod_add(s1_a, s1_b);
      s1_diff   = mod_sub(s1_a, s1_b);
      s1_mul_in = s1_mode ? s1_diff : s1_b;
      s1_op     = s1_mode ? s1_sum  : s1_a;
      s1_p      = PW'(s1_mul_in) * PW'(rom_dout);
   end

   // ------------------------------------------------------------------
   // S3 combinational: Barrett reduction of the product
   // ------------------------------------------------------------------
   logic [BW-1:0]  bar_prod;
   logic [QEW-1:0] bar_qe;
   logic [RW-1:0]  bar_qq;
   logic [RW-1:0]  bar_r0;
   logic [RW-1:0]  bar_r1;
   logic [RW-1:0]  bar_r2;
   logic [DATA_W-1:0] red_r;

   // 5039 / 2^24 slightly underestimates 1/q, so r0 is non-negative and below 3q
   always_comb begin
      bar_prod = BW'(s2_p) * BW'(BARRETT_M);
      bar_qe   = QEW'(bar_prod >> BARRETT_SHIFT);
      bar_qq   = RW'(bar_qe) * Q_RW;
      bar_r0   = RW'(s2_p) - bar_qq;
      bar_r1   = (bar_r0 >= Q_RW) ? (bar_r0 - Q_RW) : bar_r0;
      bar_r2   = (bar_r1 >= Q_RW) ? (bar_r1 - Q_RW) : bar_r1;
      red_r    = DATA_W'(bar_r2);
   end

   // ------------------------------------------------------------------
   // Output combinational: CT final add/sub, GS pass-through
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] fin_a;
   logic [DATA_W-1:0] fin_b;

   // CT produces (a + r, a - r); GS already holds (s, r)
   always_comb begin
      fin_a = s3_mode ? s3_op : mod_add(s3_op, s3_r);
      fin_b = s3_mode ? s3_r  : mod_sub(s3_op, s3_r);
   end

   // S1: capture the accepted beat; the ROM returns its zeta alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tag   <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_mode  <= in_mode;
         s1_a     <= in_a;
         s1_b     <= in_b;
         s1_tag   <= in_tag;
      end
   end

   // S2: register the product and the operand that skips the multiplier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_mode  <= 1'b0;
         s2_p     <= '0;
         s2_op    <= '0;
         s2_tag   <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         s2_p     <= s1_p;
         s2_op    <= s1_op;
         s2_tag   <= s1_tag;
      end
   end

   // S3: register the fully reduced product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid <= 1'b0;
         s3_mode  <= 1'b0;
         s3_r     <= '0;
         s3_op    <= '0;
         s3_tag   <= '0;
      end else if (advance) begin
         s3_valid <= s2_valid;
         s3_mode  <= s2_mode;
         s3_r     <= red_r;
         s3_op    <= s2_op;
         s3_tag   <= s2_tag;
      end
   end

   // OUT: result register, held while downstream is not ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_tag   <= '0;
      end else if (advance) begin
         out_valid <= s3_valid;
         out_a     <= fin_a;
         out_b     <= fin_b;
         out_tag   <= s3_tag;
      end
   end

endmodule

// File: tb/tb_ntt_zeta_butterfly.sv
// Bench for ntt_zeta_butterfly: a ROM model, a driver, and a scoreboard monitor.
module tb_ntt_zeta_butterfly;

   localparam int Q = 3329;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_mode = 1'b0;
   logic [11:0] in_a = '0;
   logic [11:0] in_b = '0;
   logic [6:0]  in_zeta_idx = '0;
   logic [7:0]  in_tag = '0;
   logic [6:0]  rom_ad;
   logic        rom_ce;
   logic        rom_oce;
   logic [11:0] rom_dout = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_a;
   logic [11:0] out_b;
   logic [7:0]  out_tag;

   int compared = 0;
   int mismatched = 0;
   int zetas[128];

   typedef struct {
      int a;
      int b;
      int tag;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   ntt_zeta_butterfly #(.DATA_W(12), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_a(in_a), .in_b(in_b), .in_zeta_idx(in_zeta_idx), .in_tag(in_tag),
      .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
   );

   // Registered zeta ROM: zeta[i] = 17^(2*bitrev7(i)+1) mod q
   always @(posedge clk) if (rom_ce) rom_dout <= 12'(zetas[rom_ad]);

   function automatic int powmod(input int base, input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = (r * base) % Q;
      return r;
   endfunction

   function automatic int bitrev7(input int x);
      int r = 0;
      for (int i = 0; i < 7; i++) r = r | (((x >> i) & 1) << (6 - i));
      return r;
   endfunction

   function automatic exp_t model(input bit m, input int a, input int b,
                                  input int idx, input int tag);
      exp_t e;
      int z = zetas[idx];
      int t;
      if (!m) begin
         t   = (b * z) % Q;
         e.a = (a + t) % Q;
         e.b = (a - t + Q) % Q;
      end else begin
         e.a = (a + b) % Q;
         e.b = (((a - b + Q) % Q) * z) % Q;
      end
      e.tag = tag;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every transfer out of the DUT
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         check("in_ready_vs_stall", int'(in_ready), int'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_result: got result tag %0d, expected none", out_tag);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (int'(out_a) != e.a || int'(out_b) != e.b || int'(out_tag) != e.tag) begin
                  mismatched++;
                  $display("FAIL result: got a=%0d b=%0d tag=%0d, expected a=%0d b=%0d tag=%0d",
                           out_a, out_b, out_tag, e.a, e.b, e.tag);
               end
            end
         end
      end
   end

   // Present one beat from a negedge until it is accepted; returns at the negedge after acceptance
   task automatic send(input bit m, input int a, input int b, input int idx,
                       input int tag, input bit rnd_ready);
      int n = 0;
      in_valid    = 1'b1;
      in_mode     = m;
      in_a        = 12'(a);
      in_b        = 12'(b);
      in_zeta_idx = 7'(idx);
      in_tag      = 8'(tag);
      forever begin
         if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
         #1;
         check("rom_ad", int'(rom_ad), idx);
         check("rom_ce", int'(rom_ce), int'(in_ready));
         if (in_ready) begin
            exp_q.push_back(model(m, a, b, idx, tag));
            @(negedge clk);
            break;
         end
         n++;
         if (n > 100) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Single beat with the exact 4-cycle latency checked
   task automatic lat_beat(input bit m, input int a, input int b, input int idx, input int tag);
      out_ready = 1'b1;
      send(m, a, b, idx, tag, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("latency_out_valid", int'(out_valid), int'(k == 4));
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int sa, sb, st, sz, n;
      for (int i = 0; i < 128; i++) zetas[i] = powmod(17, 2 * bitrev7(i) + 1);

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_rom_oce", int'(rom_oce), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_a", int'(out_a), 0);
      check("reset_out_b", int'(out_b), 0);
      check("reset_out_tag", int'(out_tag), 0);
      @(negedge clk);

      // Directed beats, including range extremes
      lat_beat(1'b0, 1, 1, 0, 8'h11);
      lat_beat(1'b1, 5, 3, 0, 8'h22);
      lat_beat(1'b0, 3328, 3328, 1, 8'h33);
      lat_beat(1'b1, 0, 3328, 1, 8'h44);
      lat_beat(1'b1, 3328, 0, 127, 8'hFF);

      // Random mixed stream with random backpressure
      for (int i = 0; i < 128; i++)
         send(1'($urandom_range(0, 1)), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
              $urandom_range(0, 127), $urandom_range(0, 255), 1'b1);
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("stream_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);

      // Fill the pipeline, then hold the output for 10 cycles
      for (int i = 0; i < 4; i++)
         send(1'(i & 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
              $urandom_range(0, 127), 100 + i, 1'b0);
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_zeta_idx = 7'($urandom_range(0, 127));
      #1;
      check("stall_full_valid", int'(out_valid), 1);
      sa = out_a; sb = out_b; st = out_tag; sz = rom_dout;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         check("stall_out_a", int'(out_a), sa);
         check("stall_out_b", int'(out_b), sb);
         check("stall_out_tag", int'(out_tag), st);
         check("stall_rom_dout", int'(rom_dout), sz);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_rom_ce", int'(rom_ce), 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("drain_consecutive", int'(out_valid), 1);
         @(negedge clk);
      end
      #1;
      check("drain_end", int'(out_valid), 0);
      @(negedge clk);

      // Asynchronous reset with beats in flight
      for (int i = 0; i < 4; i++)
         send(1'(i & 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
              $urandom_range(0, 127), 200 + i, 1'b0);
      out_ready = 1'b0;
      #1;
      check("pre_reset_valid", int'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", int'(out_valid), 0);
      check("async_reset_out_a", int'(out_a), 0);
      check("async_reset_out_b", int'(out_b), 0);
      check("async_reset_in_ready", int'(in_ready), 1);
      exp_q.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("no_stale_result", int'(out_valid), 0);
         @(negedge clk);
      end
      lat_beat(1'b0, 1234, 2345, 77, 8'h5A);
      lat_beat(1'b1, 2000, 3000, 5, 8'hA5);
      check("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
